// File: rtl/uart_codec_pkg.sv
// uart_codec_pkg: characters, command type, nibble helper and encoder states shared by the UART codec.
// The CR/LF encoder states exist only when UART_ENCODER_NEWLINE_EN is defined.
package uart_codec_pkg;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_W  = 8'h57;
    localparam logic [7:0] CH_A  = 8'h41;
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {CMD_RD = 2'b00, CMD_WR = 2'b01, CMD_ACK = 2'b10, CMD_STAT = 2'b11} cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_HEX, ST_END
`ifdef UART_ENCODER_NEWLINE_EN
        , ST_CR, ST_LF
`endif
    } enc_state_t;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    function automatic logic [7:0] cmd_to_ascii(input cmd_t c);
        return c == CMD_RD ? CH_R : c == CMD_WR ? CH_W : c == CMD_ACK ? CH_A : CH_S;
    endfunction
endpackage

// File: rtl/uart_encoder_if.sv
// uart_encoder_if: word request and byte transmitter handshake of the UART encoder.
interface uart_encoder_if;
    logic        i_stb;
    logic [33:0] i_word;
    logic        o_busy;
    logic        o_tx_stb;
    logic [7:0]  o_tx_data;
    logic        i_tx_busy;
    modport master (output i_stb, i_word, i_tx_busy, input o_busy, o_tx_stb, o_tx_data);
    modport slave  (input i_stb, i_word, i_tx_busy, output o_busy, o_tx_stb, o_tx_data);
endinterface

// File: rtl/uart_encoder.sv
// uart_encoder: serializes a 34-bit word as letter, HEX_DIGITS lowercase hex digits and 'E'.
// Define UART_ENCODER_NEWLINE_EN to append CR LF after the terminator.
module uart_encoder
    import uart_codec_pkg::*;
#(
    parameter int HEX_DIGITS = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    uart_encoder_if.slave bus
);
    localparam int SHIFT = 32 - 4 * HEX_DIGITS;

    enc_state_t  state_q;
    logic [31:0] sh_q;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic        stb_q;
    logic [7:0]  data_q;
    logic        xfer;
    logic [7:0]  dig;

    assign xfer          = stb_q && !bus.i_tx_busy;
    assign dig           = nibble_to_ascii(sh_q[31:28]);
    assign bus.o_busy    = busy_q;
    assign bus.o_tx_stb  = stb_q;
    assign bus.o_tx_data = data_q;

    // Next character is loaded on the same edge that transfers the current one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.i_stb) begin
                    sh_q    <= bus.i_word[31:0] << SHIFT;
                    data_q  <= cmd_to_ascii(cmd_t'(bus.i_word[33:32]));
                    stb_q   <= 1'b1;
                    busy_q  <= 1'b1;
                    state_q <= ST_CMD;
                end
                ST_CMD: if (xfer) begin
                    data_q  <= dig;
                    sh_q    <= sh_q << 4;
                    cnt_q   <= 3'(HEX_DIGITS - 1);
                    state_q <= ST_HEX;
                end
                ST_HEX: if (xfer) begin
                    if (cnt_q == 3'd0) begin
                        data_q  <= CH_E;
                        state_q <= ST_END;
                    end else begin
                        data_q <= dig;
                        sh_q   <= sh_q << 4;
                        cnt_q  <= cnt_q - 3'd1;
                    end
                end
`ifdef UART_ENCODER_NEWLINE_EN
                ST_END: if (xfer) begin
                    data_q  <= CH_CR;
                    state_q <= ST_CR;
                end
                ST_CR: if (xfer) begin
                    data_q  <= CH_LF;
                    state_q <= ST_LF;
                end
                ST_LF: if (xfer) begin
                    stb_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
`else
                ST_END: if (xfer) begin
                    stb_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
`endif
                default: begin
                    stb_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_encoder.sv
// tb_uart_encoder: directed vectors for an 8-digit and a 2-digit encoder sharing one stimulus path.
module tb_uart_encoder;
`ifdef UART_ENCODER_NEWLINE_EN
    localparam int NL = 2;
`else
    localparam int NL = 0;
`endif

    typedef struct packed {
        logic        sel;
        logic        rnd;
        logic [33:0] w;
        logic [3:0]  n;
        logic [79:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        stb = 1'b0;
    logic        txb = 1'b0;
    logic [33:0] word = '0;
    int          checks = 0;
    int          fails = 0;
    vec_t        vecs[6];

    uart_encoder_if e ();
    uart_encoder_if f ();

    assign e.i_stb     = stb & ~sel;
    assign f.i_stb     = stb & sel;
    assign e.i_word    = word;
    assign f.i_word    = word;
    assign e.i_tx_busy = txb;
    assign f.i_tx_busy = txb;

    uart_encoder #(.HEX_DIGITS(8)) dut8 (.i_clk(clk), .i_rst_n(rst_n), .bus(e));
    uart_encoder #(.HEX_DIGITS(2)) dut2 (.i_clk(clk), .i_rst_n(rst_n), .bus(f));

    logic       cur_busy;
    logic       cur_stb;
    logic [7:0] cur_data;
    assign cur_busy = sel ? f.o_busy : e.o_busy;
    assign cur_stb  = sel ? f.o_tx_stb : e.o_tx_stb;
    assign cur_data = sel ? f.o_tx_data : e.o_tx_data;

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_char(input logic [79:0] ex, input int n, input int k);
        if (k < n) return ex[79 - 8 * k -: 8];
        return (k == n) ? 8'h0D : 8'h0A;
    endfunction

    task automatic accept(input logic s, input logic [33:0] w);
        @(negedge clk);
        sel = s; stb = 1'b1; word = w; txb = 1'b0;
        @(negedge clk);
        stb = 1'b0; word = ~w;
        check("accept", {30'd0, cur_busy, cur_stb}, 32'd3);
    endtask

    // Runs while the encoder is busy, recording each transferred byte and checking stalls hold.
    task automatic collect(input string nm, input logic [79:0] ex, input int n, input logic rnd,
                           input logic [33:0] nxt);
        int         k = 0;
        int         cyc = 0;
        int         nt = n + NL;
        logic       pend = 1'b0;
        logic [7:0] pd = 8'h00;
        while (cur_busy && cyc < 400) begin
            txb = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            if (pend) check({nm, "_hold"}, {23'd0, cur_stb, cur_data}, {23'd0, 1'b1, pd});
            if (cur_stb && !txb) begin
                if (k < nt) check({nm, "_char"}, {24'd0, cur_data}, {24'd0, exp_char(ex, n, k)});
                k++;
            end
            if (k == 3) word = nxt;
            pend = cur_stb && txb;
            pd = cur_data;
            @(negedge clk);
            cyc++;
        end
        txb = 1'b0;
        if (cur_busy) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles", nm, cur_busy, cyc);
        end
        check({nm, "_len"}, 32'(k), 32'(nt));
        if (!rnd) check({nm, "_cycles"}, 32'(cyc), 32'(nt));
        check({nm, "_idle"}, {30'd0, cur_busy, cur_stb}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 34'h0_0000abcd, 4'd10, 80'h52_30303030_61626364_45};
        vecs[1] = '{1'b0, 1'b1, 34'h3_deadbeef, 4'd10, 80'h53_64656164_62656566_45};
        vecs[2] = '{1'b1, 1'b0, 34'h2_12345678, 4'd4, {32'h41373845, 48'h0}};
        vecs[3] = '{1'b0, 1'b0, 34'h1_00000001, 4'd10, 80'h57_30303030_30303031_45};
        vecs[4] = '{1'b1, 1'b1, 34'h3_000000a9, 4'd4, {32'h53613945, 48'h0}};
        vecs[5] = '{1'b0, 1'b0, 34'h2_9f0e1c7b, 4'd10, 80'h41_39663065_31633762_45};

        #12;
        check("rst8", {23'd0, e.o_busy, e.o_tx_stb, e.o_tx_data}, 32'd0);
        check("rst2", {23'd0, f.o_busy, f.o_tx_stb, f.o_tx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            accept(vecs[i].sel, vecs[i].w);
            collect($sformatf("vec%0d", i), vecs[i].exp, int'(vecs[i].n), vecs[i].rnd, ~vecs[i].w);
        end

        // Back-to-back words with the request held; the word seen mid-transfer must be ignored.
        @(negedge clk);
        sel = 1'b0; stb = 1'b1; word = 34'h0_00000011; txb = 1'b0;
        @(negedge clk);
        word = 34'h3_ffffffff;
        check("b2b_acc", {30'd0, cur_busy, cur_stb}, 32'd3);
        collect("b2b1", 80'h52_30303030_30303131_45, 10, 1'b0, 34'h1_00000022);
        @(negedge clk);
        stb = 1'b0; word = '0;
        check("b2b_next", {22'd0, cur_busy, cur_stb, cur_data}, {22'd0, 2'b11, 8'h57});
        collect("b2b2", 80'h57_30303030_30303232_45, 10, 1'b0, '0);

        // Reset mid-word, then a fresh word must start from its letter.
        accept(1'b0, 34'h0_0000abcd);
        repeat (4) @(negedge clk);
        check("rst_pre", {24'd0, cur_data}, 32'h30);
        #2 rst_n = 1'b0;
        #1 check("rst_mid", {22'd0, cur_busy, cur_stb, cur_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        accept(1'b0, 34'h0_0000abcd);
        collect("after_rst", 80'h52_30303030_61626364_45, 10, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
